// File: rtl/morse_player.sv
// Morse playback engine: serialises packed code slots MSB first, one bit per time unit,
// gating a free-running square tone onto beep, with start/abort/repeat handshaking.
module morse_player #(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_BITS = 18,
  parameter int TONE_HALF = 15000,
  parameter int UNIT_BASE = 50000000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  input  logic [1:0]                        speed_sel,
  input  logic [NUM_SLOTS-1:0]              slot_en,
  input  logic                              repeat_en,
  input  logic [NUM_SLOTS*SLOT_BITS-1:0]    code,
  output logic                              beep,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(NUM_SLOTS)-1:0]      cur_slot
);

  // state | meaning
  // IDLE  | waiting for start; outputs quiet
  // SEEK  | examining one slot per cycle for its enable bit
  // PLAY  | shifting out the current slot, one bit per unit
  // FIN   | end of pass: pulse done, or restart when repeating
  typedef enum logic [1:0] {IDLE, SEEK, PLAY, FIN} state_t;

  localparam int SW = $clog2(NUM_SLOTS);
  localparam int BW = $clog2(SLOT_BITS);
  localparam int TW = $clog2(TONE_HALF);
  localparam int UW = $clog2(4 * UNIT_BASE);
  localparam int CW = NUM_SLOTS * SLOT_BITS;
  localparam int IW = $clog2(CW);

  state_t state, state_n;

  logic [TW-1:0]        tone_cnt;
  logic                 tone_phase;
  logic [CW-1:0]        code_q;
  logic [NUM_SLOTS-1:0] en_q;
  logic                 rep_q;
  logic [UW-1:0]        unit_last;
  logic [UW-1:0]        unit_cnt;
  logic [BW-1:0]        bit_idx;
  logic [SW-1:0]        slot;
  logic [SW-1:0]        en_pos;
  logic [IW-1:0]        bit_pos;
  logic                 en_cur, bit_val, unit_end, last_bit, last_slot;

  // slot_en is laid out like code: its MSB belongs to slot 0
  assign en_pos    = SW'(NUM_SLOTS - 1) - slot;
  assign en_cur    = en_q[en_pos];
  assign bit_pos   = IW'((NUM_SLOTS - int'(slot)) * SLOT_BITS - 1 - int'(bit_idx));
  assign bit_val   = code_q[bit_pos];
  assign unit_end  = (unit_cnt == unit_last);
  assign last_bit  = (bit_idx == BW'(SLOT_BITS - 1));
  assign last_slot = (slot == SW'(NUM_SLOTS - 1));
  assign cur_slot  = slot;

  always_ff @(posedge clk) begin
    if (rst) begin
      tone_cnt   <= '0;
      tone_phase <= 1'b0;
    end else if (tone_cnt == TW'(TONE_HALF - 1)) begin
      tone_cnt   <= '0;
      tone_phase <= ~tone_phase;
    end else begin
      tone_cnt   <= tone_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = SEEK;
      SEEK: begin
        if (abort)          state_n = IDLE;
        else if (en_cur)    state_n = PLAY;
        else if (last_slot) state_n = FIN;
      end
      PLAY: begin
        if (abort)                     state_n = IDLE;
        else if (unit_end && last_bit) state_n = last_slot ? FIN : SEEK;
      end
      FIN: begin
        if (abort)      state_n = IDLE;
        else if (rep_q) state_n = SEEK;
        else            state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q    <= '0;
      en_q      <= '0;
      rep_q     <= 1'b0;
      unit_last <= '0;
      unit_cnt  <= '0;
      bit_idx   <= '0;
      slot      <= '0;
      beep      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      beep <= (state == PLAY) && !abort && tone_phase && bit_val;
      busy <= (state_n != IDLE);
      done <= (state == FIN) && !abort && !rep_q;
      case (state)
        IDLE: if (start) begin
          code_q    <= code;
          en_q      <= slot_en;
          rep_q     <= repeat_en;
          unit_last <= UW'(UNIT_BASE * (int'(speed_sel) + 1) - 1);
          slot      <= '0;
        end
        SEEK: if (!abort) begin
          if (en_cur) begin
            bit_idx  <= '0;
            unit_cnt <= '0;
          end else if (!last_slot) begin
            slot <= slot + 1'b1;
          end
        end
        PLAY: if (!abort) begin
          if (unit_end) begin
            unit_cnt <= '0;
            if (last_bit) begin
              bit_idx <= '0;
              if (!last_slot) slot <= slot + 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            unit_cnt <= unit_cnt + 1'b1;
          end
        end
        FIN: if (!abort && rep_q) slot <= '0;
        default: ;
      endcase
    end
  end

endmodule
